// File: rtl/crot_gate_pipelined_param.sv
// Controlled phase rotation by 2*pi/2^k on one complex amplitude.
// Four-stage stallable pipeline with round half-up and saturation.
module crot_gate_pipelined_param #(
  parameter int TOTAL_WIDTH = 6,
  parameter int FRAC_WIDTH  = 4,
  parameter int COEF_WIDTH  = 10,
  parameter int COEF_FRAC   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [TOTAL_WIDTH-1:0] ar,
  input  logic signed [TOTAL_WIDTH-1:0] ai,
  input  logic [2:0]                    k,
  input  logic                          inv,
  input  logic                          ctrl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [TOTAL_WIDTH-1:0] pr,
  output logic signed [TOTAL_WIDTH-1:0] pi,
  output logic                          out_sat
);

  localparam int PW = TOTAL_WIDTH + COEF_WIDTH;
  localparam int SW = PW + 1;
  localparam int RW = SW + 1;

  localparam logic signed [COEF_WIDTH-1:0] ONE =
    COEF_WIDTH'(1) << COEF_FRAC;
  localparam logic signed [RW-1:0] RND =
    RW'(1) << (COEF_FRAC - 1);
  localparam logic signed [RW-1:0] MAXV =
    (RW'(1) << (TOTAL_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  // Bad parameter sets are rejected at elaboration.
  if (COEF_FRAC > COEF_WIDTH - 2) begin : g_bad_coef
    $error("COEF_FRAC too large for COEF_WIDTH");
  end
  if (FRAC_WIDTH >= TOTAL_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must be below TOTAL_WIDTH");
  end

  logic signed [COEF_WIDTH-1:0] cos_tab [8];
  logic signed [COEF_WIDTH-1:0] sin_tab [8];

  // Q8 table is fixed; other formats are computed at elaboration.
  if (COEF_FRAC == 8) begin : g_rom_q8
    assign cos_tab[0] = COEF_WIDTH'(256);
    assign cos_tab[1] = COEF_WIDTH'(-256);
    assign cos_tab[2] = COEF_WIDTH'(0);
    assign cos_tab[3] = COEF_WIDTH'(181);
    assign cos_tab[4] = COEF_WIDTH'(237);
    assign cos_tab[5] = COEF_WIDTH'(251);
    assign cos_tab[6] = COEF_WIDTH'(255);
    assign cos_tab[7] = COEF_WIDTH'(256);
    assign sin_tab[0] = COEF_WIDTH'(0);
    assign sin_tab[1] = COEF_WIDTH'(0);
    assign sin_tab[2] = COEF_WIDTH'(256);
    assign sin_tab[3] = COEF_WIDTH'(181);
    assign sin_tab[4] = COEF_WIDTH'(98);
    assign sin_tab[5] = COEF_WIDTH'(50);
    assign sin_tab[6] = COEF_WIDTH'(25);
    assign sin_tab[7] = COEF_WIDTH'(13);
  end else begin : g_rom_gen
    localparam real PI_R = 3.14159265358979323846;
    for (genvar i = 0; i < 8; i++) begin : g_ent
      localparam real TH = 2.0 * PI_R / (2.0 ** i);
      localparam real SC = 2.0 ** COEF_FRAC;
      assign cos_tab[i] = COEF_WIDTH'(int'($cos(TH) * SC));
      assign sin_tab[i] = COEF_WIDTH'(int'($sin(TH) * SC));
    end
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic signed [COEF_WIDTH-1:0] c_sel, s_sel;

  // Pick effective coefficients: identity when ctrl is low.
  always_comb begin
    c_sel = ONE;
    s_sel = '0;
    if (ctrl) begin
      c_sel = cos_tab[k];
      s_sel = inv ? -sin_tab[k] : sin_tab[k];
    end
  end

  logic                          v1, v2, v3;
  logic signed [TOTAL_WIDTH-1:0] ar1, ai1;
  logic signed [COEF_WIDTH-1:0]  c1, s1;
  logic signed [PW-1:0]          p_rc, p_is, p_rs, p_ic;
  logic signed [SW-1:0]          re3, im3;

  // S1: capture operands and selected coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      ar1 <= '0;
      ai1 <= '0;
      c1  <= '0;
      s1  <= '0;
    end else if (adv) begin
      v1  <= in_valid;
      ar1 <= ar;
      ai1 <= ai;
      c1  <= c_sel;
      s1  <= s_sel;
    end
  end

  logic signed [PW-1:0] ar_x, ai_x, c_x, s_x;
  assign ar_x = PW'(ar1);
  assign ai_x = PW'(ai1);
  assign c_x  = PW'(c1);
  assign s_x  = PW'(s1);

  // S2: the four partial products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      p_rc <= '0;
      p_is <= '0;
      p_rs <= '0;
      p_ic <= '0;
    end else if (adv) begin
      v2   <= v1;
      p_rc <= ar_x * c_x;
      p_is <= ai_x * s_x;
      p_rs <= ar_x * s_x;
      p_ic <= ai_x * c_x;
    end
  end

  // S3: combine products with one guard bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3  <= 1'b0;
      re3 <= '0;
      im3 <= '0;
    end else if (adv) begin
      v3  <= v2;
      re3 <= SW'(p_rc) - SW'(p_is);
      im3 <= SW'(p_rs) + SW'(p_ic);
    end
  end

  logic signed [RW-1:0]          re_sh, im_sh;
  logic                          hi_r, lo_r, hi_i, lo_i;
  logic signed [TOTAL_WIDTH-1:0] pr_n, pi_n;

  // Round half-up, rescale, and clamp to the amplitude range.
  always_comb begin
    re_sh = (RW'(re3) + RND) >>> COEF_FRAC;
    im_sh = (RW'(im3) + RND) >>> COEF_FRAC;
    hi_r  = re_sh > MAXV;
    lo_r  = re_sh < MINV;
    hi_i  = im_sh > MAXV;
    lo_i  = im_sh < MINV;
    pr_n  = re_sh[TOTAL_WIDTH-1:0];
    pi_n  = im_sh[TOTAL_WIDTH-1:0];
    if (hi_r) pr_n = MAXV[TOTAL_WIDTH-1:0];
    if (lo_r) pr_n = MINV[TOTAL_WIDTH-1:0];
    if (hi_i) pi_n = MAXV[TOTAL_WIDTH-1:0];
    if (lo_i) pi_n = MINV[TOTAL_WIDTH-1:0];
  end

  // S4: output register; sat flag only with a valid sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pr        <= '0;
      pi        <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= v3;
      pr        <= pr_n;
      pi        <= pi_n;
      out_sat   <= v3 && (hi_r || lo_r || hi_i || lo_i);
    end
  end

endmodule

// File: tb/tb_crot_gate_pipelined_param.sv
// Directed and scoreboarded checks for crot_gate_pipelined_param.
// Each scenario task does its own comparisons.
module tb_crot_gate_pipelined_param;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic signed [5:0] ar, ai, pr, pi;
  logic [2:0]        k;
  logic              inv, ctrl;
  logic              out_valid, out_ready, out_sat;

  int tests = 0;
  int fails = 0;

  crot_gate_pipelined_param dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .k(k), .inv(inv), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .pr(pr), .pi(pi), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ar; int ai; int k; bit inv; bit ctrl;
  } smp_t;

  typedef struct {
    int epr; int epi; bit esat;
  } exp_t;

  typedef struct {
    int ar; int ai; int k; bit inv; bit ctrl;
    int epr; int epi; bit esat;
  } dvec_t;

  int cos_t [8] = '{256, -256, 0, 181, 237, 251, 255, 256};
  int sin_t [8] = '{0, 0, 256, 181, 98, 50, 25, 13};

  // Reference: Q8 coefficients, round half-up, clamp to [-32,31].
  function automatic exp_t model(input smp_t s);
    exp_t e;
    int c, sn, re, im;
    c  = 256;
    sn = 0;
    if (s.ctrl) begin
      c  = cos_t[s.k];
      sn = s.inv ? -sin_t[s.k] : sin_t[s.k];
    end
    re = s.ar * c - s.ai * sn;
    im = s.ar * sn + s.ai * c;
    re = (re + 128) >>> 8;
    im = (im + 128) >>> 8;
    e.esat = 1'b0;
    if (re > 31)  begin re = 31;  e.esat = 1'b1; end
    if (re < -32) begin re = -32; e.esat = 1'b1; end
    if (im > 31)  begin im = 31;  e.esat = 1'b1; end
    if (im < -32) begin im = -32; e.esat = 1'b1; end
    e.epr = re;
    e.epi = im;
    return e;
  endfunction

  task automatic drive(input smp_t s);
    ar   = 6'(s.ar);
    ai   = 6'(s.ai);
    k    = 3'(s.k);
    inv  = s.inv;
    ctrl = s.ctrl;
  endtask

  task automatic test_reset();
    tests++;
    if ({out_valid, out_sat, pr, pi} !== 14'd0) begin
      fails++;
      $display("FAIL reset_state: got ov=%b sat=%b pr=%0d pi=%0d, want all 0",
               out_valid, out_sat, pr, pi);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  dvec_t dv [8] = '{
    '{16,  0, 3, 1'b0, 1'b1,  11,  11, 1'b0},
    '{16,  0, 2, 1'b0, 1'b1,   0,  16, 1'b0},
    '{16,  0, 1, 1'b0, 1'b1, -16,   0, 1'b0},
    '{16, 16, 3, 1'b0, 1'b1,   0,  23, 1'b0},
    '{16,  0, 2, 1'b1, 1'b1,   0, -16, 1'b0},
    '{-32, 0, 1, 1'b0, 1'b1,  31,   0, 1'b1},
    '{-32, 0, 1, 1'b0, 1'b0, -32,   0, 1'b0},
    '{-7, 12, 0, 1'b0, 1'b1,  -7,  12, 1'b0}
  };

  task automatic test_directed();
    smp_t s;
    bit   early;
    out_ready = 1'b1;
    foreach (dv[i]) begin
      s = '{dv[i].ar, dv[i].ai, dv[i].k, dv[i].inv, dv[i].ctrl};
      drive(s);
      in_valid = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      early = 1'b0;
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); #1;
        if (e == 1) begin
          in_valid = 1'b0;
          k = ~k; inv = ~inv; ctrl = ~ctrl; ar = ~ar; ai = ~ai;
        end
        if (e < 4 && out_valid !== 1'b0) early = 1'b1;
      end
      tests++;
      if (early) begin
        fails++;
        $display("FAIL dir%0d_latency: out_valid rose before edge 4", i);
      end
      tests++;
      if (out_valid !== 1'b1 || pr !== 6'(dv[i].epr) ||
          pi !== 6'(dv[i].epi) || out_sat !== dv[i].esat) begin
        fails++;
        $display("FAIL dir%0d_result: got ov=%b pr=%0d pi=%0d sat=%b want ov=1 pr=%0d pi=%0d sat=%b",
                 i, out_valid, pr, pi, out_sat,
                 dv[i].epr, dv[i].epi, dv[i].esat);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
        fails++;
        $display("FAIL dir%0d_drain: got ov=%b sat=%b want 0 0",
                 i, out_valid, out_sat);
      end
    end
  endtask

  task automatic test_backpressure();
    smp_t              v [8];
    exp_t              q [$];
    exp_t              e;
    int                idx, got, cyc;
    logic signed [5:0] lpr, lpi;
    logic              lov, lor;
    for (int i = 0; i < 8; i++)
      v[i] = '{3 * i - 10, 13 - 4 * i, i, 1'(i), 1'b1};
    idx = 0; got = 0; cyc = 0;
    lov = 1'b0; lor = 1'b1; lpr = '0; lpi = '0;
    while (got < 8 && cyc < 200) begin
      in_valid  = idx < 8;
      if (idx < 8) drive(v[idx]);
      out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        fails++;
        $display("FAIL bp_in_ready c%0d: got %b want %b",
                 cyc, in_ready, !out_valid || out_ready);
      end
      if (lov && !lor) begin
        tests++;
        if (out_valid !== 1'b1 || pr !== lpr || pi !== lpi) begin
          fails++;
          $display("FAIL bp_hold c%0d: got ov=%b pr=%0d pi=%0d want 1 %0d %0d",
                   cyc, out_valid, pr, pi, lpr, lpi);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL bp_extra: got pr=%0d pi=%0d want no output", pr, pi);
        end else begin
          e = q.pop_front();
          if (pr !== 6'(e.epr) || pi !== 6'(e.epi) ||
              out_sat !== e.esat) begin
            fails++;
            $display("FAIL bp_out%0d: got %0d %0d %b want %0d %0d %b",
                     got, pr, pi, out_sat, e.epr, e.epi, e.esat);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(v[idx]));
        idx++;
      end
      lov = out_valid; lor = out_ready; lpr = pr; lpi = pi;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (got != 8 || q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d outputs want 8", got);
    end
  endtask

  task automatic test_reset_midstream();
    smp_t s;
    bit   early;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s = '{i + 5, -(i + 3), 3, 1'b0, 1'b1};
      drive(s);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || pr !== 6'sd8) begin
      fails++;
      $display("FAIL rst_pre: got ov=%b pr=%0d want 1 8", out_valid, pr);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_sat, pr, pi} !== 14'd0) begin
      fails++;
      $display("FAIL rst_async: got ov=%b sat=%b pr=%0d pi=%0d want all 0",
               out_valid, out_sat, pr, pi);
    end
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL rst_flush: out_valid rose after release, want 0");
    end
    s = '{-9, 20, 2, 1'b0, 1'b1};
    drive(s);
    in_valid = 1'b1;
    early = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (e < 4 && out_valid !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early || out_valid !== 1'b1 || pr !== -6'sd20 ||
        pi !== -6'sd9) begin
      fails++;
      $display("FAIL rst_restart: got ov=%b pr=%0d pi=%0d early=%b want 1 -20 -9 0",
               out_valid, pr, pi, early);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    smp_t v [32];
    exp_t q [$];
    exp_t e;
    int   idx, got, cyc, n;
    n = 0;
    for (int kk = 0; kk < 8; kk++)
      for (int iv = 0; iv < 2; iv++)
        for (int ct = 0; ct < 2; ct++) begin
          v[n] = '{int'($urandom_range(0, 63)) - 32,
                   int'($urandom_range(0, 63)) - 32,
                   kk, 1'(iv), 1'(ct)};
          n++;
        end
    idx = 0; got = 0; cyc = 0;
    while (got < 32 && cyc < 2000) begin
      in_valid  = idx < 32 && $urandom_range(0, 3) != 0;
      if (idx < 32) drive(v[idx]);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        fails++;
        $display("FAIL sw_in_ready c%0d: got %b want %b",
                 cyc, in_ready, !out_valid || out_ready);
      end
      if (!out_valid) begin
        tests++;
        if (out_sat !== 1'b0) begin
          fails++;
          $display("FAIL sw_sat_idle c%0d: got %b want 0", cyc, out_sat);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sw_extra: got pr=%0d pi=%0d want no output", pr, pi);
        end else begin
          e = q.pop_front();
          if (pr !== 6'(e.epr) || pi !== 6'(e.epi) ||
              out_sat !== e.esat) begin
            fails++;
            $display("FAIL sw_out%0d: got %0d %0d %b want %0d %0d %b",
                     got, pr, pi, out_sat, e.epr, e.epi, e.esat);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(v[idx]));
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (got != 32 || q.size() != 0) begin
      fails++;
      $display("FAIL sw_count: got %0d outputs want 32", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ar = '0; ai = '0; k = '0; inv = 1'b0; ctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_backpressure();
    repeat (4) @(posedge clk);
    #1;
    test_reset_midstream();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
